// File: rtl/result_sig_collector.sv
// result_sig_collector
// Compresses a valid/ready stream of DATA_W-bit results into a per-frame
// summary: MISR signature, saturating beat count, and unsigned min/max.
// The summary is presented on a held valid/ready port after the last beat.

module result_sig_collector #(
    parameter int               DATA_W  = 10,
    parameter int               SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = 16'h1021,
    parameter logic [SIG_W-1:0] SEED    = 16'hFFFF,
    parameter int               COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    output logic               sig_valid,
    input  logic               sig_ready,
    output logic [SIG_W-1:0]   sig_value,
    output logic [COUNT_W-1:0] sig_count,
    output logic [DATA_W-1:0]  sig_min,
    output logic [DATA_W-1:0]  sig_max
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t             state;
    logic [SIG_W-1:0]   misr;
    logic [COUNT_W-1:0] count;
    logic [DATA_W-1:0]  min_val;
    logic [DATA_W-1:0]  max_val;
    logic               accept;

    // One MISR step: shift left, fold the dropped MSB back through POLY,
    // then XOR in the zero-extended data word.
    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0]  cur,
        input logic [DATA_W-1:0] d
    );
        logic [SIG_W-1:0] ext;
        logic [SIG_W-1:0] fb;
        ext              = '0;
        ext[DATA_W-1:0]  = d;
        fb               = cur[SIG_W-1] ? POLY : '0;
        return {cur[SIG_W-2:0], 1'b0} ^ fb ^ ext;
    endfunction

    // Beat counter sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] count_sat_inc(
        input logic [COUNT_W-1:0] c
    );
        if (&c) begin
            return c;
        end
        return c + COUNT_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] umin(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return (b < a) ? b : a;
    endfunction

    function automatic logic [DATA_W-1:0] umax(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return (b > a) ? b : a;
    endfunction

    // Ready only while collecting; clear blocks acceptance so an aborted
    // cycle never contributes a beat.
    assign in_ready = (state == COLLECT) && !clear;
    assign accept   = in_valid && in_ready;

    // The accumulators double as the summary outputs; they hold their
    // frame-start values while a frame is empty.
    assign sig_value = misr;
    assign sig_count = count;
    assign sig_min   = min_val;
    assign sig_max   = max_val;

    // Frame FSM and accumulators; sig_valid is registered alongside state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            sig_valid <= 1'b0;
            misr      <= SEED;
            count     <= '0;
            min_val   <= '1;
            max_val   <= '0;
        end else if (state == COLLECT) begin
            if (clear) begin
                misr    <= SEED;
                count   <= '0;
                min_val <= '1;
                max_val <= '0;
            end else if (accept) begin
                misr    <= misr_step(misr, in_data);
                count   <= count_sat_inc(count);
                min_val <= umin(min_val, in_data);
                max_val <= umax(max_val, in_data);
                if (in_last) begin
                    state     <= HOLD;
                    sig_valid <= 1'b1;
                end
            end
        end else begin
            // HOLD: summary frozen until taken; clear has no effect here.
            if (sig_ready) begin
                state     <= COLLECT;
                sig_valid <= 1'b0;
                misr      <= SEED;
                count     <= '0;
                min_val   <= '1;
                max_val   <= '0;
            end
        end
    end

endmodule
